// File: rtl/pe_pkg.sv
// Shared constants, stage bundles and FSM state for the pe_acc accumulator.
// Lane geometry and adder-tree widths live here so every stage agrees on them.
package pe_pkg;

  localparam int LANES  = 32;
  localparam int PROD_W = 32;
  localparam int PART_W = 35;
  localparam int TREE_W = 37;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef struct packed {
    logic                   valid;
    logic                   last;
    logic [3:0][PART_W-1:0] p;
  } s1_t;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [TREE_W-1:0] sum;
  } s2_t;

endpackage

// File: rtl/pe_add8.sv
// Combinational signed adder over 8 int32 lanes.
// Each lane is sign-extended to the partial width before summing.
module pe_add8
  import pe_pkg::*;
(
  input  logic [8*PROD_W-1:0] lanes,
  output logic [PART_W-1:0]   sum
);

  // sum eight sign-extended products
  always_comb begin
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {{(PART_W-PROD_W){lanes[PROD_W*i+PROD_W-1]}},
                   lanes[PROD_W*i +: PROD_W]};
    end
  end

endmodule

// File: rtl/pe_acc.sv
// 3-stage dot-product accumulator: 32-lane tree, then ACC_W accumulator.
// Define PE_ACC_SAT_EN to clamp out_data to the int32 range.
module pe_acc
  import pe_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*PROD_W-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_data,
  output logic [7:0]              out_beats
);

  logic                   adv;
  logic [3:0][PART_W-1:0] part;
  logic [TREE_W-1:0]      tree;
  logic [ACC_W-1:0]       base;
  logic [ACC_W-1:0]       total;
  logic [7:0]             cnt_inc;
  logic [31:0]            res;

  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic [31:0]      od_q, od_d;
  logic [7:0]       ob_q, ob_d;

  assign adv       = !(ov_q && !out_ready);
  assign in_ready  = adv;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_beats = ob_q;

  for (genvar g = 0; g < 4; g++) begin : g_add
    pe_add8 u_add (
      .lanes(in_data[8*PROD_W*g +: 8*PROD_W]),
      .sum  (part[g])
    );
  end

  // S1/S2 pipeline registers advance together on adv
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    tree = '0;
    for (int k = 0; k < 4; k++) begin
      tree = tree + {{(TREE_W-PART_W){s1_q.p[k][PART_W-1]}},
                     s1_q.p[k]};
    end
    if (adv) begin
      s1_d.valid = in_valid;
      s1_d.last  = in_last;
      s1_d.p     = part;
      s2_d.valid = s1_q.valid;
      s2_d.last  = s1_q.last;
      s2_d.sum   = tree;
    end
  end

  // accumulate S2 sum; a last beat emits the result and restarts
  always_comb begin
    base    = (state_q == ACC) ? acc_q : '0;
    total   = base + {{(ACC_W-TREE_W){s2_q.sum[TREE_W-1]}},
                      s2_q.sum};
    cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
`ifdef PE_ACC_SAT_EN
    if (&total[ACC_W-1:31] || ~|total[ACC_W-1:31])
      res = total[31:0];
    else if (total[ACC_W-1])
      res = 32'h8000_0000;
    else
      res = 32'h7FFF_FFFF;
`else
    res = total[31:0];
`endif
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ob_d    = ob_q;
    if (adv) begin
      ov_d = 1'b0;
      if (s2_q.valid) begin
        if (s2_q.last) begin
          ov_d    = 1'b1;
          od_d    = res;
          ob_d    = cnt_inc;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          acc_d   = total;
          cnt_d   = cnt_inc;
          state_d = ACC;
        end
      end
    end
  end

  // state registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ob_q    <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ob_q    <= ob_d;
    end
  end

endmodule

// File: doc/pe_acc.md
PE_ACC -- requirements
Module: pe_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 48, meaning internal accumulator width in bits (legal range 40..64).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, meaning a product beat is present.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-006 SHALL have port in_data, input, 1024, meaning 32 signed int32 products; lane i occupies bits 32*i+31:32*i (the upstream multiplier format).
REQ-007 SHALL have port in_last, input, 1, meaning the beat closes the current dot product.
REQ-008 SHALL have port out_valid, output, 1, meaning a result is held on out_data.
REQ-009 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 SHALL have port out_data, output, 32, meaning the signed int32 dot-product result.
REQ-011 SHALL have port out_beats, output, 8, meaning the number of beats summed into out_data, saturating at 255.

Function
REQ-012 SHALL transfer a beat exactly when in_valid and in_ready are both 1, and a result exactly when out_valid and out_ready are both 1.
REQ-013 SHALL drive in_ready = !(out_valid && !out_ready); one global advance signal stalls every stage.
REQ-014 Stage S1 SHALL register 4 sign-extended partial sums of 35 bits each (lanes 0-7, 8-15, 16-23, 24-31), together with a valid bit and a last bit.
REQ-015 Stage S2 SHALL register the 37-bit sum of the 4 partials, together with a valid bit and a last bit.
REQ-016 Stage S3 SHALL add the S2 sum, sign-extended to ACC_W, into the accumulator; all sums SHALL use 2's-complement arithmetic.
REQ-017 SHALL run a 2-state FSM: IDLE (accumulator zero, beat count 0) and ACC (partial result held).
- IDLE -> ACC on a non-last S2 beat.
- ACC -> IDLE on a last S2 beat.
- A last beat arriving in IDLE SHALL produce a one-beat result and stay in IDLE.
REQ-018 On a last S2 beat, SHALL load out_data from (acc + sum), set out_valid = 1, load out_beats, and clear both accumulator and beat count in the same cycle.
REQ-019 Latency: with out_ready held at 1, a last beat accepted in cycle N SHALL raise out_valid in cycle N+3.
REQ-020 SHALL accept the first beat of the next vector in the cycle after a last beat, with no bubble and no mixing between vectors.
REQ-021 While a stall is active, out_data, out_beats and all stage registers SHALL hold their values.
REQ-022 SHALL clear out_valid on the cycle after a transfer, unless a new result loads in that same cycle.
REQ-023 The beat counter SHALL stick at 255 rather than wrap.

Reset
REQ-024 When rst_n is 0, SHALL asynchronously force the following to zero or IDLE: out_valid, out_data, out_beats, accumulator, beat count, FSM state, and all stage valid bits.
REQ-025 A reset asserted mid-vector SHALL discard all partial sums; the first beat accepted after release SHALL start a new vector.

Configuration
REQ-026 With macro PE_ACC_SAT_EN defined, out_data SHALL be the acc + sum value clamped to the range [32'h80000000, 32'h7FFFFFFF].
REQ-027 Without PE_ACC_SAT_EN, out_data SHALL be the low 32 bits of acc + sum (wrap-around).

Structure
REQ-028 A shared package pe_pkg SHALL hold the lane count (32), product width (32), partial width (35), tree width (37) and the FSM state typedef.
REQ-029 A single sub-module pe_add8 SHALL implement the combinational 8-lane signed adder; S1 instantiates it 4 times.

Verification
REQ-030 Single beat with every lane 32'h1, last = 1 -> out_data = 32, out_beats = 1, out_valid high 3 cycles after acceptance.
REQ-031 4 beats with every lane 32'hFFFFFFFF, last on beat 4 -> out_data = 32'hFFFFFF80 (-128), out_beats = 4.
REQ-032 2 beats with every lane 32'h7FFFFFFF -> out_data = 32'h7FFFFFFF with PE_ACC_SAT_EN; out_data = 32'hFFFFFFC0 without it.
REQ-033 Hold out_ready = 0 for 5 cycles while a result is pending -> in_ready = 0, out_data stable, no beat lost; the next result is correct after release.
REQ-034 Back-to-back vectors (A: 1 beat, all lanes 2; B: 2 beats, all lanes 1) -> results 64 then 64, with out_beats 1 then 2.
REQ-035 Assert rst_n = 0 after 2 beats of a vector, then send 1 beat with all lanes 3, last = 1 -> out_data = 96, out_beats = 1.
